uart_packet_parser: RTL

Byte-level packet framer between the UART receiver and the image-select command logic in `Top`.
- Consumes received bytes framed as CMD, LEN, payload, CHK.
- Checks length and checksum, and enforces an inter-byte timeout.
- Stores the payload in a local buffer.
- Presents a validated packet to the command handler, which executes `S` (0x53, set image) and `C` (0x43, get image).

---
 rtl/uart_pkt_pkg.sv | 27 ++
 rtl/pkt_payload_ram.sv | 38 +++
 rtl/uart_packet_parser.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet framer.
// States, error codes, command bytes and length decode.
package uart_pkt_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CHK  = 3'd3,
      ST_DONE = 3'd4,
      ST_SKIP = 3'd5
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CHK     = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_LEN     = 2'd3;

   localparam logic [7:0] CMD_SETIMG = 8'h53;
   localparam logic [7:0] CMD_GETIMG = 8'h43;

   // LEN byte 0 stands for a full 256-byte payload
   function automatic logic [8:0] decode_len(input logic [7:0] b);
      return (b == 8'd0) ? 9'd256 : {1'b0, b};
   endfunction

endpackage

// File: rtl/pkt_payload_ram.sv
// Payload buffer: one synchronous write port and one
// registered read port whose output register resets to 0.
module pkt_payload_ram #(
   parameter int NUMBER = 256,
   parameter int AW     = $clog2(NUMBER)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [NUMBER];
   logic [7:0] rdata_d;
   logic [7:0] rdata_q;

   // storage array is left unreset so it can map to block RAM
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // read mux feeding the output register
   always_comb begin
      rdata_d = mem[raddr];
   end

   // one-cycle read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rdata_q <= 8'd0;
      else     rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/uart_packet_parser.sv
// Frames CMD, LEN, payload, CHK bytes from the UART receiver,
// checks length, checksum and inter-byte timeout, holds a good packet.
module uart_packet_parser
   import uart_pkt_pkg::*;
#(
   parameter int CLOCK      = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int NUMBER     = 256,
   parameter int RX_TIMEOUT = 2
) (
   input  logic                      inclk,
   input  logic                      reset,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic                      pkt_valid,
   output logic [7:0]                pkt_cmd,
   output logic [8:0]                pkt_len,
   input  logic                      pkt_ack,
   input  logic [$clog2(NUMBER)-1:0] rd_addr,
   output logic [7:0]                rd_data,
   output logic                      pkt_err,
   output logic [1:0]                err_code,
   output logic                      pkt_drop
);

   localparam int AW = $clog2(NUMBER);
   localparam int TO = RX_TIMEOUT * 10 * (CLOCK / BAUD);
   localparam int CW = $clog2(TO + 1);
   localparam logic [8:0] MAX_LEN = 9'(NUMBER);

   state_e        state_q, state_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [8:0]    len_q, len_d;
   logic [8:0]    idx_q, idx_d;
   logic [7:0]    sum_q, sum_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;
   logic          drop_q, drop_d;
   logic          we;
   logic          tmo;
   logic [8:0]    len_dec;

   assign len_dec = decode_len(rx_data);
   assign tmo     = (cnt_q == CW'(TO - 1));

   // next-state, checksum, index and timeout logic
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      len_d   = len_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cnt_d   = 0;
      err_d   = 1'b0;
      code_d  = ERR_NONE;
      drop_d  = 1'b0;
      we      = 1'b0;
      if (rx_valid)
         cnt_d = 0;
      else if (state_q != ST_IDLE && state_q != ST_DONE)
         cnt_d = cnt_q + 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_valid) begin
               cmd_d   = rx_data;
               sum_d   = rx_data;
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            if (rx_valid) begin
               len_d = len_dec;
               sum_d = sum_q + rx_data;
               if (len_dec > MAX_LEN) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
                  state_d = ST_SKIP;
               end else begin
                  idx_d   = 9'd0;
                  state_d = ST_DATA;
               end
            end else if (tmo) begin
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
               state_d = ST_IDLE;
            end
         end
         ST_DATA: begin
            if (rx_valid) begin
               we    = 1'b1;
               sum_d = sum_q + rx_data;
               idx_d = idx_q + 9'd1;
               if (idx_q == len_q - 9'd1) state_d = ST_CHK;
            end else if (tmo) begin
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
               state_d = ST_IDLE;
            end
         end
         ST_CHK: begin
            if (rx_valid) begin
               if (rx_data == ~sum_q) begin
                  state_d = ST_DONE;
               end else begin
                  err_d   = 1'b1;
                  code_d  = ERR_CHK;
                  state_d = ST_IDLE;
               end
            end else if (tmo) begin
               err_d   = 1'b1;
               code_d  = ERR_TIMEOUT;
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (rx_valid) drop_d = 1'b1;
            if (pkt_ack)  state_d = ST_IDLE;
         end
         ST_SKIP: begin
            if (!rx_valid && tmo) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      valid_d = (state_d == ST_DONE);
   end

   // state and output registers
   always_ff @(posedge inclk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cmd_q   <= 8'd0;
         len_q   <= 9'd0;
         idx_q   <= 9'd0;
         sum_q   <= 8'd0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         code_q  <= code_d;
         drop_q  <= drop_d;
      end
   end

   pkt_payload_ram #(
      .NUMBER(NUMBER),
      .AW    (AW)
   ) u_ram (
      .clk  (inclk),
      .rst  (reset),
      .we   (we),
      .waddr(idx_q[AW-1:0]),
      .wdata(rx_data),
      .raddr(rd_addr),
      .rdata(rd_data)
   );

   assign pkt_valid = valid_q;
   assign pkt_cmd   = cmd_q;
   assign pkt_len   = len_q;
   assign pkt_err   = err_q;
   assign err_code  = code_q;
   assign pkt_drop  = drop_q;

endmodule
